// File: rtl/sound_pkg.sv
// Shared constants for the APU frame sequencer: channel indices, per-step
// tick masks and length-counter limits.
package sound_pkg;

  localparam int CH1 = 0;
  localparam int CH2 = 1;
  localparam int CH3 = 2;
  localparam int CH4 = 3;

  // Bit n set means the tick fires when leaving sequencer step n.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  function automatic logic step_hit(input logic [7:0] mask, input logic [2:0] step);
    return mask[step];
  endfunction

endpackage

// File: rtl/sound_length_ctr.sv
// One channel's length counter and active flag: load, trigger, length tick
// and kill, resolved with a fixed per-edge priority.
module sound_length_ctr
  import sound_pkg::*;
#(
  parameter int CNT_W = 7,
  parameter int MAX   = LEN_MAX_SQ,
  parameter int LD_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [LD_W-1:0]  i_data,
  input  logic             i_len_en,
  input  logic             i_trigger,
  input  logic             i_disable,
  input  logic             i_tick,
  output logic             o_active
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_act_nxt;

  assign w_load_val = CNT_W'(MAX) - CNT_W'(i_data);

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_act_nxt = r_active;
    if (i_load) w_cnt_nxt = w_load_val;
    // Trigger reload looks at the counter after any same-edge load.
    if (i_trigger) begin
      w_act_nxt = 1'b1;
      if (w_cnt_nxt == '0) w_cnt_nxt = CNT_W'(MAX);
    end else if (!i_load && i_tick && i_len_en && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) w_act_nxt = 1'b0;
    end
    if (i_disable) w_act_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_active <= w_act_nxt;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: divides clk to the frame rate, steps an 8-step
// sequence, strobes length/sweep/envelope ticks and owns four length counters.
module sound_frame_seq
  import sound_pkg::*;
#(
  parameter int CLK_DIV = 8192,
  parameter int DIV_W   = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_en,
  input  logic [3:0] len_load,
  input  logic [7:0] len_data,
  input  logic [3:0] len_enable,
  input  logic [3:0] trigger,
  input  logic [3:0] ch_disable,
  output logic [2:0] frame_step,
  output logic       tick_length,
  output logic       tick_sweep,
  output logic       tick_envelope,
  output logic [3:0] ch_active
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_step;
  logic             r_tick_len;
  logic             r_tick_sweep;
  logic             r_tick_env;
  logic [3:0]       w_active;

  // Divider and step counter; ticks decode the step being left.
  always_ff @(posedge clk) begin
    if (rst || !apu_en) begin
      r_div_cnt    <= '0;
      r_step       <= '0;
      r_tick_len   <= 1'b0;
      r_tick_sweep <= 1'b0;
      r_tick_env   <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt    <= '0;
      r_step       <= r_step + 3'd1;
      r_tick_len   <= step_hit(LEN_STEPS, r_step);
      r_tick_sweep <= step_hit(SWEEP_STEPS, r_step);
      r_tick_env   <= step_hit(ENV_STEPS, r_step);
    end else begin
      r_div_cnt    <= r_div_cnt + 1'b1;
      r_tick_len   <= 1'b0;
      r_tick_sweep <= 1'b0;
      r_tick_env   <= 1'b0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_len
    localparam bit IS_WAVE = (g == CH3);
    localparam int CW      = IS_WAVE ? 9 : 7;
    localparam int MX      = IS_WAVE ? LEN_MAX_WAVE : LEN_MAX_SQ;
    localparam int LW      = IS_WAVE ? 8 : 6;

    sound_length_ctr #(
      .CNT_W (CW),
      .MAX   (MX),
      .LD_W  (LW)
    ) u_len (
      .clk       (clk),
      .rst       (rst),
      .i_en      (apu_en),
      .i_load    (len_load[g]),
      .i_data    (len_data[LW-1:0]),
      .i_len_en  (len_enable[g]),
      .i_trigger (trigger[g]),
      .i_disable (ch_disable[g]),
      .i_tick    (r_tick_len),
      .o_active  (w_active[g])
    );
  end

  assign frame_step    = r_step;
  assign tick_length   = r_tick_len;
  assign tick_sweep    = r_tick_sweep;
  assign tick_envelope = r_tick_env;
  assign ch_active     = w_active;

endmodule
